// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch front end with a small prefetch buffer.  A fetch_pc
// register drives the instruction memory address directly. The memory
// returns the word in the same cycle. Each accepted fetch stores the
// {pc, word} pair in a circular FIFO of DEPTH entries. The consumer drains
// the FIFO through a valid/ready handshake. A redirect flushes every
// buffered entry and restarts fetching at the new (word-aligned) address.
//
// Parameters
//   DEPTH       number of buffered instructions (power of two, >= 2)
//   RESET_PC    first fetch address after reset
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   reset_n      in   asynchronous active-low reset
//   imem_a       out  [31:0] fetch address to instruction memory
//   imem_rd      in   [31:0] instruction word for imem_a (same cycle)
//   redirect     in   flush-and-jump request
//   redirect_pc  in   [31:0] new fetch address, sampled when redirect=1
//   instr_valid  out  head entry present
//   instr_ready  in   consumer accepts the head entry
//   instr        out  [31:0] head instruction word (0 when empty)
//   instr_pc     out  [31:0] address of the head instruction (0 when empty)
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0]      q_pc   [DEPTH];
  logic [31:0]      q_word [DEPTH];

  logic             not_empty;
  logic             pop;
  logic             push;

  // Handshake decode. A full queue can still accept a fetch when the head
  // leaves in the same cycle, which keeps throughput at one per cycle.
  always_comb begin
    not_empty = (count != '0);
    pop       = not_empty & instr_ready & ~redirect;
    push      = ~redirect & ((count < CNT_FULL) | pop);
  end

  assign imem_a      = fetch_pc;
  assign instr_valid = not_empty;
  assign instr       = not_empty ? q_word[rd_ptr] : 32'h0;
  assign instr_pc    = not_empty ? q_pc[rd_ptr]   : 32'h0;

  // Control state: fetch address, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset. Stale contents are never observable
  // because the outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= fetch_pc;
      q_word[wr_ptr] <= imem_rd;
    end
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, giving the number of buffered instructions (power of two, at least 2).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, the reset; asynchronous assertion, active-low.
REQ-005 SHALL have port imem_a, output, 32 bits, the fetch address to the instruction memory.
REQ-006 SHALL have port imem_rd, input, 32 bits, the instruction word, combinationally valid for imem_a in the same cycle.
REQ-007 SHALL have port redirect, input, 1 bit, the flush-and-jump request.
REQ-008 SHALL have port redirect_pc, input, 32 bits, the new fetch address, sampled when redirect=1.
REQ-009 SHALL have port instr_valid, output, 1 bit, high when the head entry is present.
REQ-010 SHALL have port instr_ready, input, 1 bit, high when the consumer accepts the head entry.
REQ-011 SHALL have port instr, output, 32 bits, the head instruction word.
REQ-012 SHALL have port instr_pc, output, 32 bits, the address the head instruction came from.

Function
REQ-013 SHALL hold a fetch_pc register; imem_a = fetch_pc combinationally at all times.
REQ-014 SHALL hold a circular FIFO of DEPTH {pc, word} entries with read pointer, write pointer and a count of 0..DEPTH.
REQ-015 SHALL set pop = instr_valid & instr_ready & ~redirect.
REQ-016 SHALL set push = ~redirect & (count < DEPTH | pop).
- Push while full is allowed only when a pop occurs in the same cycle.
REQ-017 On push, SHALL write {fetch_pc, imem_rd} at the write pointer and advance it modulo DEPTH.
- fetch_pc SHALL advance by 4, with 32-bit wrap-around: 32'hFFFF_FFFC + 4 = 0.
REQ-018 Without push, SHALL hold fetch_pc.
REQ-019 On pop, SHALL advance the read pointer modulo DEPTH.
REQ-020 Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
REQ-021 SHALL drive instr_valid = (count != 0).
REQ-022 SHALL drive instr/instr_pc from the head entry when count != 0, and 32'h0 when count = 0.
REQ-023 On redirect=1, at the next edge SHALL:
- set count = 0 and both pointers = 0;
- set fetch_pc = {redirect_pc[31:2], 2'b00};
- perform no push and no pop, regardless of instr_ready.
REQ-024 Latency:
- An instruction fetched at edge N SHALL appear at the outputs after edge N when the FIFO was empty.
- After redirect at edge N, the first post-redirect instruction SHALL be valid after edge N+1.
REQ-025 Sustained throughput SHALL be one instruction per cycle while instr_ready=1 and redirect=0.
REQ-026 instr/instr_pc SHALL remain stable while instr_valid=1 and instr_ready=0.

Reset
REQ-027 While reset_n=0, SHALL force fetch_pc=RESET_PC, count=0 and pointers=0, independent of clk.
- Consequently instr_valid=0, instr=0, instr_pc=0 and imem_a=RESET_PC during reset.
REQ-028 Reset assertion mid-operation SHALL discard all buffered entries immediately.
REQ-029 The first push SHALL occur on the first rising clk edge with reset_n=1.

Verification
REQ-030 Memory model: 0->0x02400413, 4->0x00400493, 8->0x00940333, 60->0x0129A0A3; release reset, instr_ready=1 -> consecutive cycles show (pc,instr) = (0,0x02400413), (4,0x00400493), (8,0x00940333).
REQ-031 instr_ready=0 after reset for 6 cycles -> count saturates at 4; imem_a holds 16; instr stays 0x02400413 at pc 0; ready=1 then yields pcs 0,4,8,12,16 on consecutive cycles.
REQ-032 Redirect with redirect_pc=62 while queue is full -> next cycle instr_valid=0 and imem_a=60; one cycle later instr_pc=60, instr=0x0129A0A3.
REQ-033 RESET_PC=32'hFFFF_FFF8, instr_ready=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 Full queue with instr_ready=1 -> push and pop in the same cycle; count stays 4 and no entry is lost or duplicated over 8 cycles.
REQ-035 reset_n pulsed low between clock edges with 3 entries buffered -> instr_valid=0 and imem_a=RESET_PC immediately; fetch restarts at RESET_PC after release.
